// File: rtl/apb_pkg.sv
// Shared types and the completer window decoder for the APB splitter.
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_IDX_W  = 4;

    typedef logic [APB_DATA_W/8-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } split_state_e;

    typedef struct packed {
        logic                 hit;
        logic [APB_IDX_W-1:0] idx;
    } apb_dec_t;

    // Callers zero-extend; the addr >= base test keeps the subtraction from wrapping.
    function automatic apb_dec_t apb_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned region_w,
        input int unsigned n
    );
        logic [63:0] w_off;
        apb_dec_t    dec;
        w_off   = (addr - base) >> region_w;
        dec.hit = (addr >= base) && (w_off < 64'(n));
        dec.idx = w_off[APB_IDX_W-1:0];
        return dec;
    endfunction

endpackage

// File: rtl/apb_split_timeout.sv
// ACCESS-phase watchdog: counts enabled cycles, flags the last allowed one.
module apb_split_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Expires on the edge that would complete the TIMEOUT_CYC-th ACCESS cycle.
    assign o_expired = (TIMEOUT_CYC != 0) && i_en && (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_split.sv
// Registered APB4 1-to-N splitter: decodes, replays on one completer, returns response.
module apb_split
    import apb_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          N_SLV       = 4,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned          REGION_W    = 12,
    parameter int unsigned          TIMEOUT_CYC = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_W-1:0]       PADDR,
    input  logic [DATA_W-1:0]       PWDATA,
    input  logic [DATA_W/8-1:0]     PSTRB,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_W-1:0]       PRDATA,
    output logic [N_SLV-1:0]        S_PSEL,
    output logic                    S_PENABLE,
    output logic                    S_PWRITE,
    output logic [ADDR_W-1:0]       S_PADDR,
    output logic [DATA_W-1:0]       S_PWDATA,
    output logic [DATA_W/8-1:0]     S_PSTRB,
    input  logic [N_SLV-1:0]        S_PREADY,
    input  logic [N_SLV-1:0]        S_PSLVERR,
    input  logic [N_SLV*DATA_W-1:0] S_PRDATA
);

    localparam int unsigned STRB_W = DATA_W / 8;

    split_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_n;
    logic                  r_write, w_write_n;
    logic [DATA_W-1:0]     r_wdata, w_wdata_n;
    logic [STRB_W-1:0]     r_strb, w_strb_n;
    logic [APB_IDX_W-1:0]  r_idx, w_idx_n;
    logic                  r_pready, w_pready_n;
    logic                  r_pslverr, w_pslverr_n;
    logic [DATA_W-1:0]     r_prdata, w_prdata_n;
    logic [N_SLV-1:0]      r_spsel, w_spsel_n;
    logic                  r_spenable, w_spenable_n;

    apb_dec_t              w_dec;
    logic [N_SLV-1:0]      w_new_sel, w_cur_sel;
    logic                  w_sready, w_sslverr, w_expired;
    logic [DATA_W-1:0]     w_srdata;

    assign w_dec = apb_decode(64'(PADDR), 64'(BASE_ADDR), REGION_W, N_SLV);

    // Loop-based select keeps index widths independent of N_SLV.
    always_comb begin
        w_new_sel = '0;
        w_cur_sel = '0;
        w_sready  = 1'b0;
        w_sslverr = 1'b0;
        w_srdata  = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (w_dec.idx == APB_IDX_W'(i)) begin
                w_new_sel[i] = 1'b1;
            end
            if (r_idx == APB_IDX_W'(i)) begin
                w_cur_sel[i] = 1'b1;
                w_sready     = S_PREADY[i];
                w_sslverr    = S_PSLVERR[i];
                w_srdata     = S_PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    apb_split_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clr     (w_state_nxt != ACCESS),
        .i_en      (r_state == ACCESS),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_n     = r_addr;
        w_write_n    = r_write;
        w_wdata_n    = r_wdata;
        w_strb_n     = r_strb;
        w_idx_n      = r_idx;
        w_pready_n   = 1'b0;
        w_pslverr_n  = 1'b0;
        w_prdata_n   = r_prdata;
        w_spsel_n    = '0;
        w_spenable_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_addr_n  = PADDR;
                    w_write_n = PWRITE;
                    w_wdata_n = PWDATA;
                    w_strb_n  = PSTRB;
                    w_idx_n   = w_dec.idx;
                    if (w_dec.hit) begin
                        w_state_nxt = SETUP;
                        w_spsel_n   = w_new_sel;
                    end else begin
                        w_state_nxt = RESP;
                        w_pready_n  = 1'b1;
                        w_pslverr_n = 1'b1;
                        w_prdata_n  = '0;
                    end
                end
            end
            SETUP: begin
                w_state_nxt  = ACCESS;
                w_spsel_n    = w_cur_sel;
                w_spenable_n = 1'b1;
            end
            ACCESS: begin
                // Ready takes priority over a simultaneous timeout.
                if (w_sready) begin
                    w_state_nxt = RESP;
                    w_pready_n  = 1'b1;
                    w_pslverr_n = w_sslverr;
                    w_prdata_n  = r_write ? '0 : w_srdata;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                    w_pready_n  = 1'b1;
                    w_pslverr_n = 1'b1;
                    w_prdata_n  = '0;
                end else begin
                    w_spsel_n    = w_cur_sel;
                    w_spenable_n = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_idx      <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_spsel    <= '0;
            r_spenable <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_n;
            r_write    <= w_write_n;
            r_wdata    <= w_wdata_n;
            r_strb     <= w_strb_n;
            r_idx      <= w_idx_n;
            r_pready   <= w_pready_n;
            r_pslverr  <= w_pslverr_n;
            r_prdata   <= w_prdata_n;
            r_spsel    <= w_spsel_n;
            r_spenable <= w_spenable_n;
        end
    end

    assign PREADY    = r_pready;
    assign PSLVERR   = r_pslverr;
    assign PRDATA    = r_prdata;
    assign S_PSEL    = r_spsel;
    assign S_PENABLE = r_spenable;
    assign S_PWRITE  = r_write;
    assign S_PADDR   = r_addr;
    assign S_PWDATA  = r_wdata;
    assign S_PSTRB   = r_strb;

endmodule

// File: tb/tb_apb_split.sv
// Directed bench for apb_split with a transaction-timeline model checked every cycle.
module tb_apb_split;
    import apb_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_SLV  = 4;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam int          TMO    = 16;

    logic         PCLK = 1'b0;
    logic         PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0]  PADDR, PWDATA;
    strb_t        PSTRB;
    logic         PREADY, PSLVERR;
    logic [31:0]  PRDATA;
    logic [3:0]   S_PSEL;
    logic         S_PENABLE, S_PWRITE;
    logic [31:0]  S_PADDR, S_PWDATA;
    logic [3:0]   S_PSTRB;
    logic [3:0]   S_PREADY, S_PSLVERR;
    logic [127:0] S_PRDATA;

    apb_split #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .N_SLV       (N_SLV),
        .BASE_ADDR   (BASE),
        .REGION_W    (12),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA),
        .S_PSEL    (S_PSEL),
        .S_PENABLE (S_PENABLE),
        .S_PWRITE  (S_PWRITE),
        .S_PADDR   (S_PADDR),
        .S_PWDATA  (S_PWDATA),
        .S_PSTRB   (S_PSTRB),
        .S_PREADY  (S_PREADY),
        .S_PSLVERR (S_PSLVERR),
        .S_PRDATA  (S_PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completer models: ready after waits[i] ACCESS cycles unless never[i].
    int          waits[4];
    bit          never[4];
    bit          errf[4];
    logic [31:0] rdat[4];
    int          wcnt[4];

    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            S_PREADY[i]          = S_PSEL[i] && S_PENABLE && !never[i] && (wcnt[i] >= waits[i]);
            S_PSLVERR[i]         = errf[i];
            S_PRDATA[i*32 +: 32] = rdat[i];
        end
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (S_PSEL[i] && S_PENABLE) wcnt[i] <= wcnt[i] + 1;
            else                        wcnt[i] <= 0;
        end
    end

    // Model of the current transfer as a timeline relative to its SETUP cycle.
    bit          chk_en = 0;
    bit          m_valid = 0;
    int          m_t, m_idx, m_acc;
    bit          m_mapped, m_err, m_write;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_strb;

    always @(negedge PCLK) begin
        int         k, rk;
        logic [3:0] esel;
        bit         een, erdy;
        if (chk_en) begin
            esel = '0;
            een  = 0;
            erdy = 0;
            if (m_valid) begin
                k  = cyc - m_t;
                rk = m_mapped ? 2 + m_acc : 1;
                if (m_mapped && k >= 1 && k <= 1 + m_acc) esel = 4'(1 << m_idx);
                een  = m_mapped && k >= 2 && k <= 1 + m_acc;
                erdy = (k == rk);
            end
            chk("S_PSEL", S_PSEL, esel);
            chk("S_PENABLE", S_PENABLE, een);
            chk("PREADY", PREADY, erdy);
            chk("PSLVERR", PSLVERR, erdy ? m_err : 1'b0);
            if (erdy) chk("PRDATA", PRDATA, m_rdata);
            if (esel != 0) begin
                chk("S_PADDR", S_PADDR, m_addr);
                chk("S_PWRITE", S_PWRITE, m_write);
                chk("S_PWDATA", S_PWDATA, m_wdata);
                chk("S_PSTRB", S_PSTRB, m_strb);
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output logic [31:0] rd,
                        output logic re);
        logic [31:0] off;
        bit          done;
        off      = addr - BASE;
        m_mapped = (addr >= BASE) && (off / 4096 < 4);
        m_idx    = m_mapped ? int'(off / 4096) : 0;
        m_write  = wr;
        m_addr   = addr;
        m_wdata  = wd;
        m_strb   = st;
        if (!m_mapped) begin
            m_acc = 0; m_err = 1; m_rdata = '0;
        end else if (never[m_idx]) begin
            m_acc = TMO; m_err = 1; m_rdata = '0;
        end else begin
            m_acc   = waits[m_idx] + 1;
            m_err   = errf[m_idx];
            m_rdata = wr ? 32'h0 : rdat[m_idx];
        end
        m_t     = cyc;
        m_valid = 1;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
        @(posedge PCLK); #1;
        PENABLE = 1;
        lat = -1; rd = 'x; re = 1'bx; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge PCLK);
            if (PREADY) begin
                lat = cyc - m_t; rd = PRDATA; re = PSLVERR; done = 1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL pready_wait: no PREADY within 40 cycles of addr %0h", addr);
        end
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_PREADY"}, PREADY, 0);
        chk({nm, "_PSLVERR"}, PSLVERR, 0);
        chk({nm, "_PRDATA"}, PRDATA, 0);
        chk({nm, "_S_PSEL"}, S_PSEL, 0);
        chk({nm, "_S_PENABLE"}, S_PENABLE, 0);
        chk({nm, "_S_PWRITE"}, S_PWRITE, 0);
        chk({nm, "_S_PADDR"}, S_PADDR, 0);
        chk({nm, "_S_PWDATA"}, S_PWDATA, 0);
        chk({nm, "_S_PSTRB"}, S_PSTRB, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        re;
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0; never[i] = 0; errf[i] = 0; wcnt[i] = 0;
            rdat[i]  = 32'hA000_0000 + 32'(i);
        end
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk_idle_outputs("reset");
        @(posedge PCLK); #1;
        PRESET = 0;
        chk_en = 1;

        // Zero-wait write to completer 2 with partial strobes.
        xfer(32'h4000_2010, 1, 32'hDEAD_BEEF, 4'b0101, lat, rd, re);
        chk("wr_c2_latency", lat, 3);
        chk("wr_c2_err", re, 0);
        chk("wr_c2_rdata", rd, 0);

        // Read completer 3 with three wait states.
        waits[3] = 3; rdat[3] = 32'h1234_5678;
        xfer(32'h4000_3004, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("rd_c3_latency", lat, 6);
        chk("rd_c3_rdata", rd, 32'h1234_5678);
        chk("rd_c3_err", re, 0);
        waits[3] = 0;

        // Unmapped: just past the last window and just below the base.
        xfer(32'h4000_4000, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("unmap_hi_latency", lat, 1);
        chk("unmap_hi_err", re, 1);
        chk("unmap_hi_rdata", rd, 0);
        xfer(32'h3FFF_FFFC, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("unmap_lo_latency", lat, 1);
        chk("unmap_lo_err", re, 1);
        chk("unmap_lo_rdata", rd, 0);

        // Completer 1 never ready: abort after TMO ACCESS cycles.
        never[1] = 1;
        xfer(32'h4000_1000, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("tmo_latency", lat, 18);
        chk("tmo_err", re, 1);
        chk("tmo_rdata", rd, 0);
        never[1] = 0;

        // Last word of completer 0 succeeds after the timeout.
        xfer(32'h4000_0FFC, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("c0_top_latency", lat, 3);
        chk("c0_top_rdata", rd, 32'hA000_0000);
        chk("c0_top_err", re, 0);

        // Completer error forwarded.
        errf[0] = 1;
        xfer(32'h4000_0000, 1, 32'h5555_AAAA, 4'b1111, lat, rd, re);
        chk("c0_err_latency", lat, 3);
        chk("c0_err_err", re, 1);
        errf[0] = 0;

        // Reset during ACCESS abandons the completer transfer.
        chk_en = 0; m_valid = 0;
        waits[0] = 5;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h4000_0020; PSTRB = '0;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("mid_S_PSEL", S_PSEL, 4'b0001);
        chk("mid_S_PENABLE", S_PENABLE, 1);
        @(posedge PCLK); #1;
        PRESET = 1; PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1;
        PRESET = 0;
        @(negedge PCLK);
        chk_idle_outputs("midreset");
        waits[0] = 0;
        @(posedge PCLK); #1;
        chk_en = 1;
        xfer(32'h4000_0008, 0, 32'h0, 4'b0000, lat, rd, re);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rd, 32'hA000_0000);
        chk("post_rst_err", re, 0);

        repeat (3) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
